// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Drives a DIGITS-wide common-anode seven-segment display by time
//   multiplexing. Glyphs use the 5-bit code set. The block provides double
//   buffered loading, leading-zero blanking, per-digit blink and PWM
//   brightness. A ghost guard keeps the digit off for cnt=0 of every slot.
// Ports
//   clk, rst_n   system clock, async active-low reset
//   load         one-cycle strobe; captures digits_in / dp_in into pending
//   digits_in    5-bit glyph code per digit, digit i at [5i+4:5i]
//   dp_in        decimal point request per digit (1=lit)
//   blank_lz     1=blank leading zeros
//   blink_mask   1=digit blinks
//   bright       PWM level, 0=dimmest, all-ones=full
//   seg          active-low {g,f,e,d,c,b,a,dp}, registered
//   dig_n        active-low digit enables, registered
//   frame_done   high for the last cycle of each full scan
//   busy         loaded data waiting for the next frame boundary
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int PWM_BITS     = 3,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [5*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [PWM_BITS-1:0]   bright,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [FW-1:0]             fcnt;
  logic                      phase;
  logic [DIGITS-1:0][4:0]    act, pend;
  logic [DIGITS-1:0]         act_dp, pend_dp;

  logic                      last_cnt, last_idx, boundary;
  logic [CW:0]               on_end;
  logic                      on;
  logic [DIGITS-1:0]         lz;
  logic                      zrun;
  logic [7:0]                seg_nxt;

  assign last_cnt   = (cnt == CW'(SCAN_DIV - 1));
  assign last_idx   = (idx == IW'(DIGITS - 1));
  assign boundary   = last_cnt && last_idx;
  assign frame_done = boundary;

  // PWM window: lit for 1 <= cnt < on_end; cnt=0 stays dark so seg can settle
  assign on_end = (CW+1)'((32'(bright) + 32'd1) * 32'(SCAN_DIV >> PWM_BITS));
  assign on     = (cnt != '0) && ({1'b0, cnt} < on_end);

  // Active-low {g,f,e,d,c,b,a,dp}; code 16 forces every segment incl. dp on
  function automatic logic [7:0] glyph(input logic [4:0] code, input logic dp);
    logic [6:0] s;
    case (code)
      5'd0:  s = 7'h40;  5'd1:  s = 7'h79;  5'd2:  s = 7'h24;  5'd3:  s = 7'h30;
      5'd4:  s = 7'h19;  5'd5:  s = 7'h12;  5'd6:  s = 7'h02;  5'd7:  s = 7'h78;
      5'd8:  s = 7'h00;  5'd9:  s = 7'h10;  5'd10: s = 7'h08;  5'd11: s = 7'h03;
      5'd12: s = 7'h46;  5'd13: s = 7'h21;  5'd14: s = 7'h06;  5'd15: s = 7'h0E;
      5'd16: s = 7'h00;  5'd17: s = 7'h3F;  5'd18: s = 7'h77;  5'd19: s = 7'h12;
      5'd20: s = 7'h02;  5'd21: s = 7'h09;  5'd22: s = 7'h47;  5'd23: s = 7'h7D;
      5'd24: s = 7'h5F;  default: s = 7'h7F;
    endcase
    glyph = (code == 5'd16) ? 8'h00 : {s, ~dp};
  endfunction

  // lz[i]: digit i and every digit above it hold code 0 (digit 0 exempt)
  always_comb begin
    lz   = '0;
    zrun = blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zrun  = zrun && (act[i] == 5'd0);
      lz[i] = zrun;
    end
  end

  always_comb begin
    seg_nxt = glyph(act[idx], act_dp[idx]);
    if (phase && blink_mask[idx])
      seg_nxt = 8'hFF;
    else if (lz[idx])
      seg_nxt = {7'h7F, ~act_dp[idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      fcnt    <= '0;
      phase   <= 1'b0;
      act     <= {DIGITS{5'd31}};
      pend    <= {DIGITS{5'd31}};
      act_dp  <= '0;
      pend_dp <= '0;
      busy    <= 1'b0;
      seg     <= 8'hFF;
      dig_n   <= '1;
    end else begin
      cnt <= last_cnt ? '0 : cnt + 1'b1;
      if (last_cnt)
        idx <= last_idx ? '0 : idx + 1'b1;

      if (load) begin
        pend    <= digits_in;
        pend_dp <= dp_in;
      end

      // Commit at the frame boundary; a load landing there bypasses pending
      if (boundary) begin
        act    <= load ? digits_in : pend;
        act_dp <= load ? dp_in : pend_dp;
        busy   <= 1'b0;
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else if (load) begin
        busy <= 1'b1;
      end

      seg   <= seg_nxt;
      dig_n <= on ? ~(DIGITS'(1) << idx) : '1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  localparam int D  = 4;
  localparam int S  = 8;
  localparam int P  = 2;
  localparam int BF = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load = 1'b0;
  logic [5*D-1:0] digits_in = '0;
  logic [D-1:0]   dp_in = '0;
  logic           blank_lz = 1'b0;
  logic [D-1:0]   blink_mask = '0;
  logic [P-1:0]   bright = '1;
  logic [7:0]     seg;
  logic [D-1:0]   dig_n;
  logic           frame_done, busy;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .PWM_BITS(P), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_mask(blink_mask), .bright(bright),
    .seg(seg), .dig_n(dig_n), .frame_done(frame_done), .busy(busy));

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed cycles since reset plus the two data buffers
  int           t;
  logic [4:0]   mact  [D];
  logic [4:0]   mpend [D];
  logic [D-1:0] mactdp, mpenddp;
  logic         mbusy;
  logic [7:0]   eseg;
  logic [D-1:0] edig;
  bit           rnd = 1'b1;

  function automatic logic [7:0] gl(input logic [4:0] code, input logic dp);
    logic [7:0] b;
    case (code)
      0: b = 8'h81;  1: b = 8'hF3;  2: b = 8'h49;  3: b = 8'h61;
      4: b = 8'h33;  5: b = 8'h25;  6: b = 8'h05;  7: b = 8'hF1;
      8: b = 8'h01;  9: b = 8'h21; 10: b = 8'h11; 11: b = 8'h07;
     12: b = 8'h8D; 13: b = 8'h43; 14: b = 8'h0D; 15: b = 8'h1D;
     16: return 8'h00;
     17: b = 8'h7F; 18: b = 8'hEF; 19: b = 8'h25; 20: b = 8'h05;
     21: b = 8'h13; 22: b = 8'h8F; 23: b = 8'hFB; 24: b = 8'hBF;
     default: b = 8'hFF;
    endcase
    return {b[7:1], ~dp};
  endfunction

  // Call right after reset is released on a negedge: the following posedge
  // consumes the post-reset state (cnt 0, digit dark, blank data).
  task automatic model_reset();
    for (int i = 0; i < D; i++) begin mact[i] = 5'd31; mpend[i] = 5'd31; end
    mactdp = '0; mpenddp = '0; mbusy = 1'b0;
    eseg = 8'hFF; edig = '1;
    t = 1;
  endtask

  task automatic run(input int n, input int load_pct);
    int c, ix, ph, on_end;
    bit bnd, lzb;
    logic [D-1:0] one;
    one = 1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c   = t % S;
      ix  = (t / S) % D;
      bnd = (c == S - 1) && (ix == D - 1);
      ph  = ((t / (S * D)) / BF) % 2;
      chk("seg", seg, eseg);
      chk("dig_n", dig_n, edig);
      chk("frame_done", frame_done, bnd);
      chk("busy", busy, mbusy);

      load = (load_pct > 0) &&
             (($urandom_range(99) < load_pct) || (bnd && $urandom_range(1) == 1));
      if (load) begin
        for (int i = 0; i < D; i++)
          digits_in[5*i +: 5] = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31));
        dp_in = D'($urandom);
      end
      if (rnd) begin
        if ($urandom_range(40) == 0) bright     = P'($urandom);
        if ($urandom_range(40) == 0) blank_lz   = 1'($urandom);
        if ($urandom_range(60) == 0) blink_mask = D'($urandom);
      end

      lzb = blank_lz && (ix > 0);
      for (int j = ix; j < D; j++) if (mact[j] != 5'd0) lzb = 1'b0;
      if (ph == 1 && blink_mask[ix]) eseg = 8'hFF;
      else if (lzb)                  eseg = {7'h7F, ~mactdp[ix]};
      else                           eseg = gl(mact[ix], mactdp[ix]);
      on_end = (int'(bright) + 1) * (S >> P);
      edig = (c >= 1 && c < on_end) ? ~(one << ix) : '1;

      if (load) begin
        for (int i = 0; i < D; i++) mpend[i] = digits_in[5*i +: 5];
        mpenddp = dp_in;
        mbusy = 1'b1;
      end
      if (bnd) begin
        for (int i = 0; i < D; i++) mact[i] = mpend[i];
        mactdp = mpenddp;
        mbusy = 1'b0;
      end
      t++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_dig_n", dig_n, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    model_reset();

    run(200, 0);       // idle: blank display, regular frame_done
    run(3000, 4);      // random loads, brightness, blanking, blink

    // Park on digit 2 fully bright, then reset asynchronously mid-slot
    rnd = 1'b0; bright = '1; blink_mask = '0;
    run(2, 0);
    while ((t % S) != 3 || ((t / S) % D) != 2) run(1, 0);
    run(1, 0);
    chk("pre_rst_dig_n", dig_n, 4'b1011);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_dig_n", dig_n, 4'hF);
    chk("async_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    run(150, 0);       // blank until a new load
    rnd = 1'b1;
    run(600, 4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
